// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue_pkg
// Brief  : Shared constants and entry type for the fetch queue.
// Rev    : 1.0
// ============================================================================
package fetch_queue_pkg;

    localparam int c_DEPTH_DEFAULT = 8;
    localparam int c_ENTRY_W       = 64;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_ram.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue_ram
// Brief  : DEPTH x 64-bit register array, two write ports, two async reads.
// Rev    : 1.0
// ============================================================================
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [c_ENTRY_W-1:0] wdata0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [c_ENTRY_W-1:0] wdata1,
    input  logic [AW-1:0]        raddr0,
    output logic [c_ENTRY_W-1:0] rdata0,
    input  logic [AW-1:0]        raddr1,
    output logic [c_ENTRY_W-1:0] rdata1
);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];

    // The controller never aims both ports at one entry; port 1 wins if it did.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we1 && (waddr1 == AW'(i))) begin
                    r_mem[i] <= wdata1;
                end else if (we0 && (waddr0 == AW'(i))) begin
                    r_mem[i] <= wdata0;
                end
            end
        end
    end

    assign rdata0 = r_mem[raddr0];
    assign rdata1 = r_mem[raddr1];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue
// Brief  : Two-wide in / two-wide out show-ahead instruction fetch queue.
// Rev    : 1.0
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Flush,
    input  logic                       InValidA,
    input  logic                       InValidB,
    input  logic [31:0]                PCPlus4InA,
    input  logic [31:0]                InstrInA,
    input  logic [31:0]                PCPlus4InB,
    input  logic [31:0]                InstrInB,
    output logic                       InReady,
    input  logic                       StallD,
    output logic                       ValidOutA,
    output logic                       ValidOutB,
    output logic [31:0]                PCPlus4OutA,
    output logic [31:0]                InstrOutA,
    output logic [31:0]                PCPlus4OutB,
    output logic [31:0]                InstrOutB,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_push_ok;
    logic [CW-1:0] w_push_cnt;
    logic [CW-1:0] w_pop_cnt;
    logic          w_we0;
    logic          w_we1;
    logic [c_ENTRY_W-1:0] w_wdata0;
    logic [c_ENTRY_W-1:0] w_rdata0;
    logic [c_ENTRY_W-1:0] w_rdata1;
    fq_entry_t     w_slot_a;
    fq_entry_t     w_slot_b;

    assign InReady   = (r_count <= CW'(DEPTH - 2));
    assign ValidOutA = (r_count >= CW'(1));
    assign ValidOutB = (r_count >= CW'(2));
    assign Count     = r_count;

    assign w_push_ok  = InReady && !Flush;
    assign w_push_cnt = w_push_ok ? (CW'(InValidA) + CW'(InValidB)) : '0;
    assign w_pop_cnt  = (!StallD && !Flush) ? (CW'(ValidOutA) + CW'(ValidOutB)) : '0;

    // Port 0 takes the oldest pushed instruction (A, or B alone); port 1 only B of a pair.
    assign w_we0    = w_push_ok && (InValidA || InValidB);
    assign w_we1    = w_push_ok && InValidA && InValidB;
    assign w_wdata0 = InValidA ? {PCPlus4InA, InstrInA} : {PCPlus4InB, InstrInB};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (Flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_cnt);
            r_tail  <= r_tail + AW'(w_push_cnt);
            r_count <= r_count + w_push_cnt - w_pop_cnt;
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we0    (w_we0),
        .waddr0 (r_tail),
        .wdata0 (w_wdata0),
        .we1    (w_we1),
        .waddr1 (r_tail + AW'(1)),
        .wdata1 ({PCPlus4InB, InstrInB}),
        .raddr0 (r_head),
        .rdata0 (w_rdata0),
        .raddr1 (r_head + AW'(1)),
        .rdata1 (w_rdata1)
    );

    assign w_slot_a    = ValidOutA ? fq_entry_t'(w_rdata0) : '0;
    assign w_slot_b    = ValidOutB ? fq_entry_t'(w_rdata1) : '0;
    assign PCPlus4OutA = w_slot_a.pc_plus4;
    assign InstrOutA   = w_slot_a.instr;
    assign PCPlus4OutB = w_slot_b.pc_plus4;
    assign InstrOutB   = w_slot_b.instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_queue
// Brief  : Scoreboard-based self-checking bench for fetch_queue (DEPTH=8).
// Rev    : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          Flush, InValidA, InValidB, StallD;
    logic [31:0]   PCPlus4InA, InstrInA, PCPlus4InB, InstrInB;
    logic          InReady, ValidOutA, ValidOutB;
    logic [31:0]   PCPlus4OutA, InstrOutA, PCPlus4OutB, InstrOutB;
    logic [CW-1:0] Count;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [63:0]   sb[$];
    logic [31:0]   next_pc;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValidA(InValidA), .InValidB(InValidB),
        .PCPlus4InA(PCPlus4InA), .InstrInA(InstrInA),
        .PCPlus4InB(PCPlus4InB), .InstrInB(InstrInB),
        .InReady(InReady), .StallD(StallD),
        .ValidOutA(ValidOutA), .ValidOutB(ValidOutB),
        .PCPlus4OutA(PCPlus4OutA), .InstrOutA(InstrOutA),
        .PCPlus4OutB(PCPlus4OutB), .InstrOutB(InstrOutB),
        .Count(Count)
    );

    function automatic logic [63:0] model_slot(input int i);
        return (i < sb.size()) ? sb[i] : 64'h0;
    endfunction

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {8'hC0, pc[23:0]};
    endfunction

    task automatic set_idle();
        InValidA = 1'b0; InValidB = 1'b0; StallD = 1'b1; Flush = 1'b0;
        PCPlus4InA = '0; InstrInA = '0; PCPlus4InB = '0; InstrInB = '0;
    endtask

    // Drive one cycle; expected contents move through the scoreboard queue.
    task automatic cycle(input logic va, input logic vb,
                         input logic [31:0] pa, input logic [31:0] ia,
                         input logic [31:0] pb, input logic [31:0] ib,
                         input logic stall, input logic flush);
        int pre;
        InValidA = va; InValidB = vb; StallD = stall; Flush = flush;
        PCPlus4InA = pa; InstrInA = ia; PCPlus4InB = pb; InstrInB = ib;
        pre = sb.size();
        if (flush) begin
            sb.delete();
        end else begin
            if (!stall) begin
                for (int k = 0; k < 2; k++) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                end
            end
            if ((DEPTH - pre) >= 2) begin
                if (va) sb.push_back({pa, ia});
                if (vb) sb.push_back({pb, ib});
            end
        end
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic push_seq(input logic va, input logic vb, input logic stall);
        logic [31:0] pa, pb;
        pa = next_pc;
        pb = va ? next_pc + 32'd4 : next_pc;
        cycle(va, vb, pa, instr_of(pa), pb, instr_of(pb), stall, 1'b0);
        next_pc = next_pc + (va ? 32'd4 : 32'd0) + (vb ? 32'd4 : 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        #12;
        n_checks++;
        if (Count !== '0 || ValidOutA !== 1'b0 || ValidOutB !== 1'b0 || InReady !== 1'b1)
            $display("FAIL reset_ctl: Count=%0d VA=%b VB=%b RDY=%b want 0 0 0 1", Count, ValidOutA, ValidOutB, InReady);
        else n_pass++;
        n_checks++;
        if ({PCPlus4OutA, InstrOutA, PCPlus4OutB, InstrOutB} !== 128'h0)
            $display("FAIL reset_data: got %h %h %h %h want zeros", PCPlus4OutA, InstrOutA, PCPlus4OutB, InstrOutB);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_two_wide();
        cycle(1'b1, 1'b1, 32'h0000_0004, 32'h2408_0001, 32'h0000_0008, 32'h2409_0002, 1'b1, 1'b0);
        n_checks++;
        if (Count !== CW'(2) || ValidOutA !== 1'b1 || ValidOutB !== 1'b1)
            $display("FAIL two_wide_ctl: Count=%0d VA=%b VB=%b want 2 1 1", Count, ValidOutA, ValidOutB);
        else n_pass++;
        n_checks++;
        if (InstrOutA !== 32'h2408_0001 || InstrOutB !== 32'h2409_0002 || PCPlus4OutB !== 32'h8)
            $display("FAIL two_wide_data: A=%h B=%h pcB=%h want 24080001 24090002 8", InstrOutA, InstrOutB, PCPlus4OutB);
        else n_pass++;
        next_pc = 32'h0000_000C;
    endtask

    task automatic test_fill();
        push_seq(1'b1, 1'b1, 1'b1);
        push_seq(1'b1, 1'b1, 1'b1);
        push_seq(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (Count !== CW'(7) || InReady !== 1'b0)
            $display("FAIL fill_full: Count=%0d RDY=%b want 7 0", Count, InReady);
        else n_pass++;
        cycle(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0004, 32'hDEAD_0005, 1'b1, 1'b0);
        n_checks++;
        if (Count !== CW'(7) || sb.size() != 7)
            $display("FAIL fill_drop: Count=%0d want 7", Count);
        else n_pass++;
        cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        n_checks++;
        if (Count !== CW'(sb.size()) || InReady !== 1'b1)
            $display("FAIL fill_pop: Count=%0d RDY=%b want %0d 1", Count, InReady, sb.size());
        else n_pass++;
        n_checks++;
        if ({PCPlus4OutA, InstrOutA} !== model_slot(0) || {PCPlus4OutB, InstrOutB} !== model_slot(1))
            $display("FAIL fill_head: got %h/%h want %h/%h", PCPlus4OutA, PCPlus4OutB, model_slot(0) >> 32, model_slot(1) >> 32);
        else n_pass++;
    endtask

    task automatic test_b_only();
        do_reset();
        next_pc = 32'h0000_0100;
        push_seq(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (Count !== CW'(1) || ValidOutB !== 1'b0 || InstrOutA !== instr_of(32'h100) || InstrOutB !== 32'h0)
            $display("FAIL b_only: Count=%0d VB=%b A=%h B=%h want 1 0 %h 0", Count, ValidOutB, InstrOutA, InstrOutB, instr_of(32'h100));
        else n_pass++;
        push_seq(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (Count !== CW'(3) || PCPlus4OutB !== 32'h104 || {PCPlus4OutA, InstrOutA} !== model_slot(0))
            $display("FAIL b_then_pair: Count=%0d pcA=%h pcB=%h want 3 100 104", Count, PCPlus4OutA, PCPlus4OutB);
        else n_pass++;
    endtask

    task automatic test_pop_push();
        logic [31:0] old_pc;
        cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        next_pc = 32'h0000_0200;
        push_seq(1'b1, 1'b0, 1'b1);
        old_pc = PCPlus4OutA;
        push_seq(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (Count !== CW'(2) || PCPlus4OutA === old_pc || PCPlus4OutA !== 32'h204 || PCPlus4OutB !== 32'h208)
            $display("FAIL pop_push: Count=%0d pcA=%h pcB=%h want 2 204 208", Count, PCPlus4OutA, PCPlus4OutB);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int errs;
        errs = 0;
        for (int c = 0; c < 7; c++) begin
            push_seq(1'b1, 1'b1, 1'b0);
            if (Count !== CW'(2) || {PCPlus4OutA, InstrOutA} !== model_slot(0) ||
                {PCPlus4OutB, InstrOutB} !== model_slot(1) || PCPlus4OutB !== PCPlus4OutA + 32'd4) begin
                errs++;
                $display("FAIL wrap_order: cyc=%0d Count=%0d pcA=%h pcB=%h want 2 %h %h", c, Count,
                         PCPlus4OutA, PCPlus4OutB, model_slot(0) >> 32, model_slot(1) >> 32);
            end
        end
        n_checks++;
        if (errs == 0) n_pass++;
        n_checks++;
        if (PCPlus4OutA !== next_pc - 32'd8)
            $display("FAIL wrap_final: pcA=%h want %h", PCPlus4OutA, next_pc - 32'd8);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        next_pc = 32'h0000_0300;
        push_seq(1'b1, 1'b1, 1'b1);
        push_seq(1'b1, 1'b1, 1'b1);
        push_seq(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (Count !== CW'(5))
            $display("FAIL flush_pre: Count=%0d want 5", Count);
        else n_pass++;
        cycle(1'b1, 1'b1, 32'hBAD0_0000, 32'hBAD0_0001, 32'hBAD0_0004, 32'hBAD0_0005, 1'b0, 1'b1);
        n_checks++;
        if (Count !== '0 || ValidOutA !== 1'b0 || ValidOutB !== 1'b0 ||
            {PCPlus4OutA, InstrOutA, PCPlus4OutB, InstrOutB} !== 128'h0 || InReady !== 1'b1)
            $display("FAIL flush: Count=%0d VA=%b pcA=%h iA=%h want 0 0 0 0", Count, ValidOutA, PCPlus4OutA, InstrOutA);
        else n_pass++;
        next_pc = 32'h0000_0400;
        push_seq(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (Count !== CW'(2) || {PCPlus4OutA, InstrOutA} !== model_slot(0) || PCPlus4OutA !== 32'h400)
            $display("FAIL flush_restart: Count=%0d pcA=%h want 2 400", Count, PCPlus4OutA);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        time t0;
        push_seq(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (Count !== CW'(3))
            $display("FAIL areset_pre: Count=%0d want 3", Count);
        else n_pass++;
        @(negedge clk);
        #1;
        t0 = $time;
        reset = 1'b1;
        sb.delete();
        #1;
        n_checks++;
        if (Count !== '0 || ValidOutA !== 1'b0 || InstrOutA !== 32'h0 || ($time - t0) >= 4)
            $display("FAIL areset: Count=%0d VA=%b iA=%h want 0 0 0", Count, ValidOutA, InstrOutA);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        next_pc = '0;
        test_reset();
        test_two_wide();
        test_fill();
        test_b_only();
        test_pop_push();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of instruction entries; it is a power of two and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port Flush, input, 1 bit, meaning discard all queued instructions (redirect).
REQ-005 The block SHALL have ports InValidA and InValidB, input, 1 bit each, meaning fetch slot A/B carries an instruction.
REQ-006 The block SHALL have ports PCPlus4InA, InstrInA, PCPlus4InB and InstrInB, input, 32 bits each, meaning the fetched slot data.
REQ-007 The block SHALL have port InReady, output, 1 bit, meaning at least 2 entries are free.
REQ-008 The block SHALL have port StallD, input, 1 bit, meaning the decode stage cannot accept this cycle.
REQ-009 The block SHALL have ports ValidOutA and ValidOutB, output, 1 bit each, meaning the head entry / second entry is present.
REQ-010 The block SHALL have ports PCPlus4OutA, InstrOutA, PCPlus4OutB and InstrOutB, output, 32 bits each, meaning the head and second entry, which feed the decode pipeline register slots A/B.
REQ-011 The block SHALL have port Count, output, $clog2(DEPTH)+1 bits, meaning the number of occupied entries.

Function
REQ-012 InReady SHALL be combinational: 1 iff (DEPTH - Count) >= 2.
REQ-013 Push SHALL occur only when InReady=1 and Flush=0; push count = InValidA + InValidB.
REQ-014 Pushed entries SHALL be written in program order: A first, then B. If only InValidB=1, B is written alone at the tail.
REQ-015 Writes presented while InReady=0 SHALL be dropped; the fetch stage holds them.
REQ-016 Outputs SHALL be show-ahead (combinational from storage): slot A = entry at head, slot B = entry at head+1 mod DEPTH.
REQ-017 ValidOutA SHALL equal (Count>=1), and ValidOutB SHALL equal (Count>=2).
REQ-018 Data outputs of an invalid slot SHALL be driven to 32'h0.
REQ-019 Pop SHALL occur when StallD=0 and Flush=0; pop count = ValidOutA + ValidOutB (0, 1 or 2).
REQ-020 Pop SHALL be based on pre-edge Count; entries pushed this cycle are not visible at the outputs until the next cycle (no bypass).
REQ-021 On simultaneous push and pop: Count_next = Count + pushes - pops; head and tail SHALL advance independently, mod DEPTH.
REQ-022 Head and tail pointers SHALL wrap from DEPTH-1 to 0; a two-entry push/pop straddling the wrap SHALL split correctly.
REQ-023 Flush SHALL have priority: at the next edge head=tail=Count=0, and that cycle's push and pop are ignored.
REQ-024 Count SHALL never exceed DEPTH nor underflow under any legal stimulus.

Reset
REQ-025 While reset=1, head, tail and Count SHALL be 0, so ValidOutA=ValidOutB=0, all data outputs are 0 and InReady=1.
REQ-026 Storage SHALL also reset to zero, and reset asserted mid-operation SHALL discard all contents immediately and asynchronously.

Structure
REQ-027 A shared package SHALL hold the DEPTH default constant and a packed entry typedef {pc_plus4[31:0], instr[31:0]}.
REQ-028 Storage SHALL be one sub-module, fetch_queue_ram: a DEPTH x 64-bit register array with two write ports and two combinational read ports.
REQ-029 Pointer and count control logic SHALL reside in fetch_queue.

Verification
REQ-030 Reset then push A=(0x0000_0004, 0x2408_0001) and B=(0x0000_0008, 0x2409_0002) with StallD=1 -> next cycle Count=2, ValidOutA=ValidOutB=1, InstrOutA=0x2408_0001, InstrOutB=0x2409_0002.
REQ-031 Fill to Count=7 with StallD=1 (DEPTH=8) -> InReady=0, and a further push leaves Count=7; pop 2 -> InReady=1.
REQ-032 Count=1 with StallD=0 and a simultaneous 2-wide push -> next cycle Count=2, and the old head is not re-presented.
REQ-033 Push 14 entries, each a 2-wide push at a cycle where 2 were popped (crossing the pointer wrap) -> outputs keep program order, PCPlus4 values ascending by 4.
REQ-034 Count=5 with Flush=1, a push and StallD=0 -> next cycle Count=0, ValidOutA=0, data outputs 0.
REQ-035 Assert reset asynchronously mid-cycle with Count=3 -> ValidOutA=0 and Count=0 before the next clk edge.
